mac_vert_col_sequencer: RTL and testbench
=========================================

// Module: mac_vert_col_sequencer
// PURPOSE
//  Control FSM for one bit-serial vertical MAC unit (32-lane, no multiplier, 2-stage psum->accum pipe).
//  Accepts a job (weight precision, K-tile count) and steps weight columns MSB-first per tile.
//  Drives column_idx / is_msb / en_acc / load_accum, stalling on the column-metadata stream.
//  Flushes the psum pipeline, then presents the finished accumulator via a valid/ready handshake.
// PARAMETERS
//  COL_W   3  width of column index (max 8 weight bits)
//  TILE_W  8  width of tile-count field (1..2^TILE_W K-tiles per output)
//  PERF_W  32 width of perf counters (only with MAC_SEQ_PERF_CNT_EN)
// PORTS
//  clk             in   1       clock
//  reset           in   1       synchronous, active-high
//  start_valid     in   1       job request
//  start_ready     out  1       job accepted when start_valid&start_ready
//  cfg_cols_m1     in   COL_W   weight bits minus 1; sampled at job accept
//  cfg_tiles_m1    in   TILE_W  K-tiles minus 1; sampled at job accept
//  meta_valid      in   1       act_sel/act_val/is_skip_zero/sum_act for current column present
//  meta_ready      out  1       current column consumed this cycle
//  mac_en_acc      out  1       MAC pipeline advance
//  mac_load_accum  out  1       MAC selects accum_prev instead of accum_out
//  mac_column_idx  out  COL_W   shift amount for current column
//  mac_is_msb      out  1       negate current column (two's-complement MSB)
//  mac_zero_psum   out  1       datapath forces act_val=0, is_skip_zero=1 (psum = 0)
//  out_valid       out  1       MAC result final
//  out_ready       in   1       result taken when out_valid&out_ready
//  busy            out  1       state != IDLE
//  perf_stall_cnt  out  PERF_W  [MAC_SEQ_PERF_CNT_EN] RUN cycles with meta_valid=0
//  perf_job_cnt    out  PERF_W  [MAC_SEQ_PERF_CNT_EN] completed jobs
// BEHAVIOUR
//  States IDLE, RUN, DRAIN, DONE. Reset -> IDLE; all outputs 0 except start_ready=1; counters 0.
//  IDLE: start_ready=1; on accept latch cfg, col_cnt=cols_m1, tile_cnt=0, first=1 -> RUN.
//  RUN: meta_ready=1; fire = meta_valid. mac_en_acc = fire; no fire => all MAC outputs frozen (stall).
//   mac_column_idx = col_cnt; mac_is_msb = (col_cnt==cols_m1) (cols_m1=0 => every column msb).
//   mac_load_accum = fire & first; first cleared on first fire (only 1st column of 1st tile).
//   On fire: col_cnt==0 ? (col_cnt<=cols_m1, tile_cnt++) : col_cnt--.
//   Fire with col_cnt==0 and tile_cnt==tiles_m1 -> DRAIN.
//  DRAIN (1 cycle): mac_en_acc=1, mac_zero_psum=1, meta_ready=0, load_accum=0, idx=0, msb=0.
//   Commits last psum into accum and leaves psum reg = 0 (invariant: psum reg 0 at job start;
//   hence first-column accum_out = 0 + accum_prev). -> DONE.
//  DONE: out_valid=1, mac_en_acc=0 (result held). out_ready -> IDLE; start_ready=0 until IDLE.
//  Latency: job accept -> out_valid = 1 + cols*tiles + stall cycles + 1 (DRAIN).
//  start_valid while busy: ignored (not accepted). out_ready outside DONE: ignored.
//  meta_valid outside RUN: ignored, never consumed.
//  Reset mid-job: -> IDLE next edge, outputs to reset values; MAC is reset by the same reset.
//  Counters: col_cnt COL_W bits, tile_cnt TILE_W bits, no wrap beyond cfg values.
// CONFIGURATION
//  MAC_SEQ_PERF_CNT_EN defined: perf_stall_cnt +1 per RUN cycle with meta_valid=0;
//   perf_job_cnt +1 per out_valid&out_ready; both wrap modulo 2^PERF_W, cleared only by reset.
//  Undefined: counter logic absent, perf_* ports tied to 0; FSM behaviour identical.
// TESTING
//  1) reset, cols_m1=7, tiles_m1=0, meta_valid=1 -> idx 7..0, msb only @7, load_accum only @7,
//     DRAIN 1 cyc, out_valid 10 cycles after accept.
//  2) cols_m1=3, tiles_m1=2, meta_valid=1 -> idx 3,2,1,0 x3, msb 3 times, load_accum once, 12 fires.
//  3) cols_m1=7, meta_valid low 2 cycles mid-job -> en_acc low, idx held, perf_stall_cnt=2, out +2 cycles.
//  4) hold out_ready=0 5 cycles in DONE -> out_valid stays, en_acc=0, start_ready=0; new start_valid ignored.
//  5) reset asserted during RUN at col 4 -> IDLE next edge, start_ready=1, busy=0; new job runs cleanly.
//  6) cols_m1=0, tiles_m1=3 with MAC model -> 4 fires all msb, accum = accum_prev - sum of 4 tile psums.

Source files
------------

// File: rtl/mac_vert_col_sequencer.sv
// mac_vert_col_sequencer: column/tile sequencer for a bit-serial vertical MAC with psum->accum pipe.
//  Optional perf counters: define MAC_SEQ_PERF_CNT_EN (otherwise perf_* ports read 0).
//  Ports: clk, reset (sync, active-high);
//         start_valid/start_ready + cfg_cols_m1/cfg_tiles_m1 : job request, cfg sampled at accept;
//         meta_valid/meta_ready : column-metadata stream, one column per handshake;
//         mac_en_acc, mac_load_accum, mac_column_idx, mac_is_msb, mac_zero_psum : MAC controls;
//         out_valid/out_ready : finished-accumulator handshake; busy : not idle;
//         perf_stall_cnt, perf_job_cnt : RUN stall cycles and completed jobs.
module mac_vert_col_sequencer #(
  parameter int COL_W  = 3,
  parameter int TILE_W = 8,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [COL_W-1:0]  cfg_cols_m1,
  input  logic [TILE_W-1:0] cfg_tiles_m1,
  input  logic              meta_valid,
  output logic              meta_ready,
  output logic              mac_en_acc,
  output logic              mac_load_accum,
  output logic [COL_W-1:0]  mac_column_idx,
  output logic              mac_is_msb,
  output logic              mac_zero_psum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_job_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t             state_q, state_d;
  logic [COL_W-1:0]   cols_m1_q, cols_m1_d, col_cnt_q, col_cnt_d;
  logic [TILE_W-1:0]  tiles_m1_q, tiles_m1_d, tile_cnt_q, tile_cnt_d;
  logic               first_q, first_d;
  logic               run, fire, col_last, job_last;
  assign run      = state_q == RUN;
  assign fire     = run & meta_valid;
  assign col_last = col_cnt_q == '0;
  assign job_last = col_last & (tile_cnt_q == tiles_m1_q);
  assign start_ready    = state_q == IDLE;
  assign busy           = state_q != IDLE;
  assign meta_ready     = run;
  assign mac_zero_psum  = state_q == DRAIN;
  // DRAIN advances the pipe once more with a zero psum to commit the last column
  assign mac_en_acc     = fire | mac_zero_psum;
  assign mac_load_accum = fire & first_q;
  assign mac_column_idx = run ? col_cnt_q : '0;
  assign mac_is_msb     = run & (col_cnt_q == cols_m1_q);
  assign out_valid      = state_q == DONE;
  always_comb begin
    state_d    = state_q;
    cols_m1_d  = cols_m1_q;
    tiles_m1_d = tiles_m1_q;
    col_cnt_d  = col_cnt_q;
    tile_cnt_d = tile_cnt_q;
    first_d    = first_q;
    if (start_ready & start_valid) begin
      state_d    = RUN;
      cols_m1_d  = cfg_cols_m1;
      tiles_m1_d = cfg_tiles_m1;
      col_cnt_d  = cfg_cols_m1;
      tile_cnt_d = '0;
      first_d    = 1'b1;
    end
    if (fire) begin
      first_d    = 1'b0;
      col_cnt_d  = col_last ? cols_m1_q : col_cnt_q - COL_W'(1);
      // tile count stops at tiles_m1 so it never wraps past the configured range
      tile_cnt_d = (col_last & ~job_last) ? tile_cnt_q + TILE_W'(1) : tile_cnt_q;
      state_d    = job_last ? DRAIN : RUN;
    end
    if (state_q == DRAIN) state_d = DONE;
    if (out_valid & out_ready) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cols_m1_q  <= '0;
      tiles_m1_q <= '0;
      col_cnt_q  <= '0;
      tile_cnt_q <= '0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cols_m1_q  <= cols_m1_d;
      tiles_m1_q <= tiles_m1_d;
      col_cnt_q  <= col_cnt_d;
      tile_cnt_q <= tile_cnt_d;
      first_q    <= first_d;
    end
  end
`ifdef MAC_SEQ_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d, job_cnt_q, job_cnt_d;
  always_comb begin
    stall_cnt_d = (run & ~meta_valid) ? stall_cnt_q + PERF_W'(1) : stall_cnt_q;
    job_cnt_d   = (out_valid & out_ready) ? job_cnt_q + PERF_W'(1) : job_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      job_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      job_cnt_q   <= job_cnt_d;
    end
  end
  assign perf_stall_cnt = stall_cnt_q;
  assign perf_job_cnt   = job_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_job_cnt   = '0;
`endif
endmodule

// File: tb/tb_mac_vert_col_sequencer.sv
// tb_mac_vert_col_sequencer: table-driven cycle checks plus reset and MAC-model sequences.
module tb_mac_vert_col_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [2:0]  cfg_cols_m1 = '0;
  logic [7:0]  cfg_tiles_m1 = '0;
  logic        meta_valid = 1'b0;
  logic        meta_ready;
  logic        mac_en_acc, mac_load_accum, mac_is_msb, mac_zero_psum;
  logic [2:0]  mac_column_idx;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic [31:0] perf_stall_cnt, perf_job_cnt;
  int checks = 0;
  int failures = 0;
  int stall_total = 0;
  int jobs = 0;
  always #5 clk = ~clk;
  mac_vert_col_sequencer dut (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
    .cfg_cols_m1(cfg_cols_m1), .cfg_tiles_m1(cfg_tiles_m1), .meta_valid(meta_valid),
    .meta_ready(meta_ready), .mac_en_acc(mac_en_acc), .mac_load_accum(mac_load_accum),
    .mac_column_idx(mac_column_idx), .mac_is_msb(mac_is_msb), .mac_zero_psum(mac_zero_psum),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .perf_stall_cnt(perf_stall_cnt), .perf_job_cnt(perf_job_cnt)
  );
  // Expected-output word layout: {start_ready, busy, meta_ready, en_acc, load_accum, idx[2:0], is_msb, zero_psum, out_valid}
  typedef struct packed {
    logic        sv;
    logic [2:0]  cols;
    logic [7:0]  tiles;
    logic        mv;
    logic        ordy;
    logic [10:0] exp;
  } vec_t;
  vec_t tbl[$];
  function automatic logic [10:0] pk(logic sr, logic bz, logic mr, logic en, logic ld,
                                     logic [2:0] idx, logic msb, logic zp, logic ov);
    return {sr, bz, mr, en, ld, idx, msb, zp, ov};
  endfunction
  function automatic logic [10:0] act();
    return {start_ready, busy, meta_ready, mac_en_acc, mac_load_accum, mac_column_idx,
            mac_is_msb, mac_zero_psum, out_valid};
  endfunction
  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, a, e);
    end
  endtask
  task automatic add_row(input logic sv, input logic [2:0] c, input logic [7:0] t,
                         input logic mv, input logic ordy, input logic [10:0] e);
    tbl.push_back({sv, c, t, mv, ordy, e});
  endtask
  // Builds the full cycle-by-cycle expectation of one job: accept, columns MSB-first per tile
  // (with an optional stall window), one DRAIN cycle, then DONE held for wait_n cycles.
  task automatic add_job(input logic [2:0] c, input logic [7:0] t, input int stall_at,
                         input int stall_len, input int wait_n);
    int n, f, cyc;
    logic [2:0] idx;
    n = (int'(c) + 1) * (int'(t) + 1);
    f = 0;
    cyc = 0;
    add_row(1'b1, c, t, 1'b1, 1'b0, pk(1, 0, 0, 0, 0, 3'd0, 0, 0, 0));
    while (f < n) begin
      idx = 3'(int'(c) - (f % (int'(c) + 1)));
      if (cyc >= stall_at && cyc < stall_at + stall_len) begin
        add_row(1'b0, 3'd0, 8'd0, 1'b0, 1'b0, pk(0, 1, 1, 0, 0, idx, idx == c, 0, 0));
        stall_total++;
      end else begin
        add_row(1'b0, 3'd0, 8'd0, 1'b1, 1'b0, pk(0, 1, 1, 1, f == 0, idx, idx == c, 0, 0));
        f++;
      end
      cyc++;
    end
    add_row(1'b1, 3'd0, 8'd0, 1'b1, 1'b1, pk(0, 1, 0, 1, 0, 3'd0, 0, 1, 0));
    for (int i = 0; i < wait_n; i++)
      add_row(1'b1, 3'd5, 8'd5, 1'b1, 1'b0, pk(0, 1, 0, 0, 0, 3'd0, 0, 0, 1));
    add_row(1'b0, 3'd0, 8'd0, 1'b1, 1'b1, pk(0, 1, 0, 0, 0, 3'd0, 0, 0, 1));
    jobs++;
  endtask
  task automatic run_tbl(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      start_valid  = tbl[i].sv;
      cfg_cols_m1  = tbl[i].cols;
      cfg_tiles_m1 = tbl[i].tiles;
      meta_valid   = tbl[i].mv;
      out_ready    = tbl[i].ordy;
      @(negedge clk);
      check($sformatf("%s_row%0d", tag, i), 32'(act()), 32'(tbl[i].exp));
      @(posedge clk);
      #1;
    end
    tbl.delete();
    start_valid = 1'b0;
    meta_valid  = 1'b0;
    out_ready   = 1'b0;
  endtask
  // Two-stage MAC model: psum of the current column, then accumulate the previous psum.
  localparam logic signed [15:0] ACCUM_PREV = 16'sd100;
  logic signed [15:0] vals [4];
  logic signed [15:0] psum_m, accum_m, vv;
  logic [1:0] fire_n;
  int msb_fires;
  assign vv = vals[fire_n];
  always @(posedge clk) begin
    if (reset) begin
      psum_m    <= '0;
      accum_m   <= '0;
      fire_n    <= '0;
      msb_fires <= 0;
    end else if (mac_en_acc) begin
      psum_m  <= mac_zero_psum ? 16'sd0 : ((mac_is_msb ? -vv : vv) <<< mac_column_idx);
      accum_m <= (mac_load_accum ? ACCUM_PREV : accum_m) + psum_m;
      if (!mac_zero_psum) begin
        fire_n <= fire_n + 2'd1;
        if (mac_is_msb) msb_fires <= msb_fires + 1;
      end
    end
  end
  int lat;
  initial begin
    vals[0] = 16'sd5;
    vals[1] = 16'sd9;
    vals[2] = 16'sd2;
    vals[3] = 16'sd7;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'(act()), 32'(pk(1, 0, 0, 0, 0, 3'd0, 0, 0, 0)));
    check("reset_perf_stall", perf_stall_cnt, 32'd0);
    check("reset_perf_job", perf_job_cnt, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    add_job(3'd7, 8'd0, 99, 0, 0);
    add_job(3'd3, 8'd2, 99, 0, 0);
    add_job(3'd7, 8'd0, 3, 2, 0);
    add_job(3'd1, 8'd0, 99, 0, 5);
    add_row(1'b0, 3'd0, 8'd0, 1'b1, 1'b1, pk(1, 0, 0, 0, 0, 3'd0, 0, 0, 0));
    run_tbl("jobs");
`ifdef MAC_SEQ_PERF_CNT_EN
    check("perf_stall_cnt", perf_stall_cnt, 32'(stall_total));
    check("perf_job_cnt", perf_job_cnt, 32'(jobs));
`else
    check("perf_stall_cnt_off", perf_stall_cnt, 32'd0);
    check("perf_job_cnt_off", perf_job_cnt, 32'd0);
`endif
    start_valid = 1'b1;
    cfg_cols_m1 = 3'd7;
    cfg_tiles_m1 = 8'd0;
    meta_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("midjob_idx", 32'(mac_column_idx), 32'd4);
    check("midjob_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_outputs", 32'(act()), 32'(pk(1, 0, 0, 0, 0, 3'd0, 0, 0, 0)));
    reset = 1'b0;
    meta_valid = 1'b0;
    add_job(3'd2, 8'd0, 99, 0, 0);
    add_row(1'b0, 3'd0, 8'd0, 1'b0, 1'b0, pk(1, 0, 0, 0, 0, 3'd0, 0, 0, 0));
    run_tbl("after_rst");
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    start_valid = 1'b1;
    cfg_cols_m1 = 3'd0;
    cfg_tiles_m1 = 8'd3;
    meta_valid = 1'b1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 start_valid = 1'b0;
      lat++;
    end
    check("mac_latency", 32'(lat), 32'd6);
    check("mac_msb_fires", 32'(msb_fires), 32'd4);
    check("mac_accum", 32'(accum_m), 32'(16'sd77));
    check("mac_psum_drained", 32'(psum_m), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    meta_valid = 1'b0;
    check("mac_back_idle", 32'(act()), 32'(pk(1, 0, 0, 0, 0, 3'd0, 0, 0, 0)));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
